ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have a parameter DIGITS, default 4, range 1..8: the number of display digits buffered.
REQ-002 The block SHALL have a parameter REPEAT_FILTER, default 1: 1 = suppress typematic repeat makes, 0 = pass them.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port code_valid, input, 1: one-cycle strobe; code_in holds a complete PS/2 scancode byte.
REQ-006 Port code_in, input, 8: scancode byte, sampled only when code_valid=1.
REQ-007 Port key_valid, output, 1: one-cycle pulse; a mapped key event is on key_code/key_break.
REQ-008 Port key_code, output, 8: key value; 0..9 digits, 11 +, 12 -, 13 *, 14 /, 15 delete, 16 enter, 17 delete-all.
REQ-009 Port key_break, output, 1: qualifies key_valid; 1 = release, 0 = press.
REQ-010 Port overflow, output, 1: one-cycle pulse; a digit was discarded because the buffer was full.
REQ-011 Port digit_count, output, 4: number of digits held, 0..DIGITS.
REQ-012 Port seg, output, 7*DIGITS: active-low segments gfedcba per digit; slice 0 = most recent digit.

Function
REQ-013 Prefix FSM states SHALL be IDLE, BRK, EXT and EXT_BRK.
REQ-014 Prefix FSM transitions: IDLE+F0 -> BRK; IDLE+E0 -> EXT; EXT+F0 -> EXT_BRK; any other byte completes a code and returns to IDLE.
REQ-015 Codes with EXT set SHALL map only 4A (/) and 5A (enter); all other extended codes are dropped silently.
REQ-016 Non-extended mapping SHALL be: 70,69,72,7A,6B,73,74,6C,75,7D -> 0..9; 79 -> +; 7B -> -; 7C -> *; 4A -> /; 71 -> delete; 5A -> enter; 66 -> delete-all.
REQ-017 Unmapped completed codes, including letters and E1, SHALL produce no event and leave the buffer unchanged.
REQ-018 key_valid, key_code, key_break and the buffer update SHALL be registered, 1 cycle after the code_valid cycle that completes the code.
REQ-019 key_code and key_break SHALL hold their last value between events.
REQ-020 When REPEAT_FILTER=1, a register pair held_valid/held_code SHALL track the last pressed mapped key.
REQ-021 When REPEAT_FILTER=1, a press equal to held_code while held_valid=1 SHALL be suppressed: no event and no buffer change.
REQ-022 A break of held_code SHALL clear held_valid.
REQ-023 Breaks SHALL emit key_valid with key_break=1 and SHALL never alter the buffer.
REQ-024 Digit press with count<DIGITS SHALL shift the buffer up, insert the digit at slot 0, and increment the count.
REQ-025 Digit press with count=DIGITS SHALL leave the buffer unchanged and pulse overflow together with key_valid.
REQ-026 Delete press SHALL shift the buffer down and decrement the count; at count=0 it is a no-op and the event is still emitted.
REQ-027 Delete-all press SHALL set count=0.
REQ-028 Operator and enter presses SHALL emit events only and leave the buffer unchanged.
REQ-029 seg slots at index >= count SHALL be blank (7'b1111111).
REQ-030 seg digit patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-031 code_valid may assert on consecutive cycles; every byte SHALL be consumed with no loss.

Reset
REQ-032 On rst: FSM=IDLE; key_valid=0, key_code=0, key_break=0, overflow=0; count=0; held_valid=0; all seg slots blank.
REQ-033 rst asserted mid-sequence (after F0 or E0) SHALL discard the pending prefix.
REQ-034 On rst, the first byte after release SHALL be treated as a fresh code.

Structure
REQ-035 Package ps2_pkg SHALL hold the scancode constants, key_code constants (KEY_ADD..KEY_CLR), prefix FSM state enum and blank pattern.
REQ-036 One sub-module seg7_digit (4-bit value -> 7-bit active-low) SHALL be instantiated DIGITS times.

Verification
REQ-037 Bytes 16? no: 69,F0,69 -> key_valid press code 1, then break code 1; digit_count=1; seg[6:0]=1111001.
REQ-038 DIGITS=4, presses 1,2,3,4,5 -> fifth press pulses overflow; seg reads 1,2,3,4 (slot0=4); count=4.
REQ-039 Bytes E0,4A then E0,F0,4A -> press then break, code 14; buffer unchanged; E0,75 -> no event.
REQ-040 REPEAT_FILTER=1, bytes 73,73,73,F0,73 -> exactly one press and one break event.
REQ-041 Digits 7,8 then 71 -> count=1, slot0=7; 71 at count=0 -> event code 15, count stays 0; 66 -> count=0.
REQ-042 Bytes F0, then rst pulse, then 70 -> press code 0 (not a break).

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keypad decoder:
//   - PS/2 set-2 scancode constants for the keys the decoder understands
//   - key_code values emitted on the decoder's key_code output
//   - prefix FSM state enum
//   - active-low blank segment pattern
//   - map_scancode(): completed scancode (+ extended flag) -> key_code
// ----------------------------------------------------------------------------
package ps2_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_EXT = 8'hE0;

   // Digit scancodes (numeric keypad)
   localparam logic [7:0] SC_0   = 8'h70;
   localparam logic [7:0] SC_1   = 8'h69;
   localparam logic [7:0] SC_2   = 8'h72;
   localparam logic [7:0] SC_3   = 8'h7A;
   localparam logic [7:0] SC_4   = 8'h6B;
   localparam logic [7:0] SC_5   = 8'h73;
   localparam logic [7:0] SC_6   = 8'h74;
   localparam logic [7:0] SC_7   = 8'h6C;
   localparam logic [7:0] SC_8   = 8'h75;
   localparam logic [7:0] SC_9   = 8'h7D;

   // Operator / editing scancodes
   localparam logic [7:0] SC_ADD = 8'h79;
   localparam logic [7:0] SC_SUB = 8'h7B;
   localparam logic [7:0] SC_MUL = 8'h7C;
   localparam logic [7:0] SC_DIV = 8'h4A;
   localparam logic [7:0] SC_DEL = 8'h71;
   localparam logic [7:0] SC_ENT = 8'h5A;
   localparam logic [7:0] SC_CLR = 8'h66;

   // Emitted key codes (0..9 are the digits themselves)
   localparam logic [7:0] KEY_DIG_MAX = 8'd9;
   localparam logic [7:0] KEY_ADD     = 8'd11;
   localparam logic [7:0] KEY_SUB     = 8'd12;
   localparam logic [7:0] KEY_MUL     = 8'd13;
   localparam logic [7:0] KEY_DIV     = 8'd14;
   localparam logic [7:0] KEY_DEL     = 8'd15;
   localparam logic [7:0] KEY_ENT     = 8'd16;
   localparam logic [7:0] KEY_CLR     = 8'd17;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic       hit;
      logic [7:0] code;
   } key_map_t;

   // Extended codes only carry keypad '/' and keypad enter; everything else
   // behind an E0 prefix (arrows, nav cluster) is deliberately ignored.
   function automatic key_map_t map_scancode(input logic ext, input logic [7:0] sc);
      key_map_t m;
      m.hit  = 1'b1;
      m.code = 8'd0;
      if (ext) begin
         case (sc)
            SC_DIV:  m.code = KEY_DIV;
            SC_ENT:  m.code = KEY_ENT;
            default: m.hit  = 1'b0;
         endcase
      end else begin
         case (sc)
            SC_0:    m.code = 8'd0;
            SC_1:    m.code = 8'd1;
            SC_2:    m.code = 8'd2;
            SC_3:    m.code = 8'd3;
            SC_4:    m.code = 8'd4;
            SC_5:    m.code = 8'd5;
            SC_6:    m.code = 8'd6;
            SC_7:    m.code = 8'd7;
            SC_8:    m.code = 8'd8;
            SC_9:    m.code = 8'd9;
            SC_ADD:  m.code = KEY_ADD;
            SC_SUB:  m.code = KEY_SUB;
            SC_MUL:  m.code = KEY_MUL;
            SC_DIV:  m.code = KEY_DIV;
            SC_DEL:  m.code = KEY_DEL;
            SC_ENT:  m.code = KEY_ENT;
            SC_CLR:  m.code = KEY_CLR;
            default: m.hit  = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/seg7_digit.sv
// ----------------------------------------------------------------------------
// seg7_digit
// Decimal digit to active-low 7-segment pattern (bit order gfedcba).
// Values above 9 produce a blank pattern.
//   value_i : 4-bit digit value
//   seg_o   : 7-bit active-low segments, seg_o[0] = a
// ----------------------------------------------------------------------------
module seg7_digit
   import ps2_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (value_i)
         4'd0:    seg_o = 7'b1000000;
         4'd1:    seg_o = 7'b1111001;
         4'd2:    seg_o = 7'b0100100;
         4'd3:    seg_o = 7'b0110000;
         4'd4:    seg_o = 7'b0011001;
         4'd5:    seg_o = 7'b0010010;
         4'd6:    seg_o = 7'b0000010;
         4'd7:    seg_o = 7'b1111000;
         4'd8:    seg_o = 7'b0000000;
         4'd9:    seg_o = 7'b0010000;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
// Turns a stream of complete PS/2 set-2 scancode bytes into keypad events and
// maintains a small digit-entry buffer rendered onto 7-segment displays.
//
// Parameters
//   DIGITS        : number of buffered/displayed digits (1..8)
//   REPEAT_FILTER : 1 = drop typematic repeat makes of the key still held
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   code_valid    : one-cycle strobe, code_in carries a scancode byte
//   code_in       : scancode byte
//   key_valid     : one-cycle pulse, key_code/key_break carry an event
//   key_code      : 0..9 digits, 11..17 operators/editing keys
//   key_break     : 1 = release, 0 = press
//   overflow      : one-cycle pulse, digit press discarded (buffer full)
//   digit_count   : digits currently held
//   seg           : active-low gfedcba per slot, slot 0 = newest digit
// ----------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int REPEAT_FILTER = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  code_valid,
   input  logic [7:0]            code_in,
   output logic                  key_valid,
   output logic [7:0]            key_code,
   output logic                  key_break,
   output logic                  overflow,
   output logic [3:0]            digit_count,
   output logic [7*DIGITS-1:0]   seg
);

   localparam logic [3:0] DIGITS_C = 4'(DIGITS);

   ps2_state_e state_q, state_d;

   logic       key_valid_q, key_valid_d;
   logic [7:0] key_code_q,  key_code_d;
   logic       key_break_q, key_break_d;
   logic       overflow_q,  overflow_d;
   logic [3:0] count_q,     count_d;
   logic       held_valid_q, held_valid_d;
   logic [7:0] held_code_q,  held_code_d;
   logic [3:0] digits_q [DIGITS];
   logic [3:0] digits_d [DIGITS];

   logic       done;
   logic       is_ext;
   logic       is_brk;
   key_map_t   map;
   logic       repeat_hit;

   // Prefix FSM: collects F0/E0 prefixes and flags the byte completing a code.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      is_ext  = 1'b0;
      is_brk  = 1'b0;
      if (code_valid) begin
         case (state_q)
            IDLE: begin
               if (code_in == SC_BRK) begin
                  state_d = BRK;
               end else if (code_in == SC_EXT) begin
                  state_d = EXT;
               end else begin
                  done = 1'b1;
               end
            end
            BRK: begin
               done    = 1'b1;
               is_brk  = 1'b1;
               state_d = IDLE;
            end
            EXT: begin
               if (code_in == SC_BRK) begin
                  state_d = EXT_BRK;
               end else begin
                  done    = 1'b1;
                  is_ext  = 1'b1;
                  state_d = IDLE;
               end
            end
            EXT_BRK: begin
               done    = 1'b1;
               is_ext  = 1'b1;
               is_brk  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign map        = map_scancode(is_ext, code_in);
   assign repeat_hit = (REPEAT_FILTER != 0) && held_valid_q && (held_code_q == map.code);

   // Event generation and buffer update for a completed, mapped code.
   always_comb begin
      key_valid_d  = 1'b0;
      overflow_d   = 1'b0;
      key_code_d   = key_code_q;
      key_break_d  = key_break_q;
      count_d      = count_q;
      held_valid_d = held_valid_q;
      held_code_d  = held_code_q;
      digits_d     = digits_q;

      if (done && map.hit) begin
         if (is_brk) begin
            key_valid_d = 1'b1;
            key_code_d  = map.code;
            key_break_d = 1'b1;
            if (held_valid_q && (held_code_q == map.code)) begin
               held_valid_d = 1'b0;
            end
         end else if (!repeat_hit) begin
            key_valid_d  = 1'b1;
            key_code_d   = map.code;
            key_break_d  = 1'b0;
            held_valid_d = 1'b1;
            held_code_d  = map.code;
            if (map.code <= KEY_DIG_MAX) begin
               if (count_q < DIGITS_C) begin
                  for (int i = DIGITS - 1; i > 0; i--) begin
                     digits_d[i] = digits_q[i-1];
                  end
                  digits_d[0] = map.code[3:0];
                  count_d     = count_q + 4'd1;
               end else begin
                  overflow_d = 1'b1;
               end
            end else if (map.code == KEY_DEL) begin
               if (count_q != 4'd0) begin
                  for (int i = 0; i < DIGITS - 1; i++) begin
                     digits_d[i] = digits_q[i+1];
                  end
                  count_d = count_q - 4'd1;
               end
            end else if (map.code == KEY_CLR) begin
               count_d = 4'd0;
            end
         end
      end
   end

   // Control and output state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         key_valid_q  <= 1'b0;
         key_code_q   <= 8'd0;
         key_break_q  <= 1'b0;
         overflow_q   <= 1'b0;
         count_q      <= 4'd0;
         held_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         key_break_q  <= key_break_d;
         overflow_q   <= overflow_d;
         count_q      <= count_d;
         held_valid_q <= held_valid_d;
      end
   end

   // Buffer contents and held key are qualified by count_q / held_valid_q,
   // so they need no reset.
   always_ff @(posedge clk) begin
      held_code_q <= held_code_d;
      digits_q    <= digits_d;
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_seg
         logic [6:0] raw;
         seg7_digit u_seg (
            .value_i (digits_q[g]),
            .seg_o   (raw)
         );
         assign seg[7*g +: 7] = (4'(g) < count_q) ? raw : SEG_BLANK;
      end
   endgenerate

   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_break   = key_break_q;
   assign overflow    = overflow_q;
   assign digit_count = count_q;

endmodule
